tlc_input_conditioner: RTL and testbench
========================================

Name: tlc_input_conditioner

Overview:
- Upstream input stage for the traffic light controller FSM.
- Synchronizes and debounces the raw pushbutton `walkButton` and the vehicle detector `Sensor`.
- Emits a clean level for the sensor and a sticky walk request, held until the controller acknowledges it.
- Runs on the board clock, ahead of the clock divider domain; the FSM samples its outputs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronized input must differ from its debounced value before the change is accepted (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each debounce counter.

Ports:
- clk  input  1  board clock; all flops on rising edge.
- rst  input  1  asynchronous, active-high reset.
- walkButton  input  1  raw pedestrian button, asynchronous to clk, bouncy.
- Sensor  input  1  raw vehicle sensor, asynchronous to clk, bouncy.
- walk_ack  input  1  one-cycle pulse from the controller: walk request taken.
- sensor_active  output  1  debounced Sensor level.
- walk_press_pulse  output  1  one-cycle pulse per accepted button press.
- walk_req  output  1  sticky pending pedestrian request.

Behaviour:
- Reset (async, rst=1): all synchronizer flops, both debounced levels, both counters, walk_press_pulse, walk_req and sensor_active go to 0; walk FSM goes to W_IDLE. Release is sampled on the next clk edge.
- Synchronizer: two flops per raw input (s1, s2); s2 is the only signal used downstream.
- Debouncer, per input, counter cnt and debounced level db:
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to db before terminal count restarts the count from 0.
- Latency: a raw edge held stable reaches s2 after 2 edges. db changes on the DEBOUNCE_CYCLES-th edge after that (edge 2+DEBOUNCE_CYCLES counting from the first capture).
- sensor_active = db of Sensor (direct register output, no extra delay).
- Edge detect: db_walk_d is db_walk delayed one cycle. walk_press_pulse <= db_walk & ~db_walk_d (registered), so it is high exactly one cycle, the cycle after db_walk rises.
- Walk FSM (3 states, walk_req = 1 only in W_PENDING):
  - W_IDLE: on the same condition that sets walk_press_pulse -> W_PENDING, so walk_req rises in the same cycle as walk_press_pulse. walk_ack in W_IDLE is ignored.
  - W_PENDING: on walk_ack -> W_LOCKOUT if db_walk=1, else W_IDLE. Further presses are absorbed with no double counting; walk_press_pulse still fires.
  - W_LOCKOUT: on db_walk=0 -> W_IDLE. A held button cannot re-request after acknowledge.
- Simultaneous walk_ack and press edge in W_IDLE: press wins -> W_PENDING.
- walk_ack held high for multiple cycles: behaves as a single ack.
- Button released and re-pressed while W_PENDING: request stays single; a second pulse is emitted.
- Sensor debounce is independent of the walk path; both inputs may change in the same cycle.
- rst asserted mid-count or in any state: immediate return to the reset values above; no request survives reset.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle: hold rst 3 cycles, inputs 0 -> all outputs 0 throughout, FSM W_IDLE.
- Clean press: walkButton 0->1 held 20 cycles -> db_walk rises on edge 6 after the change; walk_press_pulse high exactly 1 cycle (edge 7), walk_req 1 from edge 7 onward.
- Bounce reject: walkButton toggles 1,0,1,0 every 2 cycles then stays 0 -> no pulse, walk_req stays 0. Sensor high for 3 cycles only -> sensor_active stays 0.
- Ack with button held: walk_req=1, pulse walk_ack 1 cycle while button still high -> walk_req 0 next cycle. FSM W_LOCKOUT until release is debounced (4 cycles after s2 falls), then W_IDLE. New press -> walk_req 1 again.
- Simultaneous events: release the button (debounced) while in W_PENDING, then assert walk_ack in the exact cycle a new press edge registers -> walk_req stays 1. Separately, ack with no request in W_IDLE -> no effect.
- Async reset mid-operation: assert rst between clk edges while walk_req=1 and the sensor counter is at 2 -> outputs 0 immediately (before next edge). After release, sensor_active needs a full 4-cycle stable window again.

Source files
------------

// File: rtl/tlc_input_conditioner_if.sv
// Signal bundle between the raw pedestrian/vehicle inputs, the controller's
// acknowledge, and the conditioned outputs consumed by the traffic light FSM.
interface tlc_input_conditioner_if;
    logic walkButton;
    logic Sensor;
    logic walk_ack;
    logic sensor_active;
    logic walk_press_pulse;
    logic walk_req;

    // Driver side: raw inputs and acknowledge out, conditioned levels in.
    modport master (
        output walkButton, Sensor, walk_ack,
        input  sensor_active, walk_press_pulse, walk_req
    );

    // Conditioner side: raw inputs and acknowledge in, conditioned levels out.
    modport slave (
        input  walkButton, Sensor, walk_ack,
        output sensor_active, walk_press_pulse, walk_req
    );
endinterface

// File: rtl/tlc_input_conditioner.sv
// Input conditioner for the traffic light controller: two-flop synchronizers
// and counter debouncers for the pedestrian button and vehicle sensor, a
// press edge detector, and a sticky walk request held until acknowledged.
module tlc_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic                      clk,
    input logic                      rst,
    tlc_input_conditioner_if.slave   bus
);

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_PENDING = 2'd1,
        W_LOCKOUT = 2'd2
    } walk_state_t;

    // Index 0 is the walk button, index 1 is the vehicle sensor.
    localparam int               WALK   = 0;
    localparam int               SENSE  = 1;
    localparam logic [CNT_W-1:0] TERM   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db;
    logic [CNT_W-1:0] cnt [2];
    logic             db_walk_d;
    logic             press_pulse;
    logic             ack_d;
    logic             press_edge;
    logic             ack_rise;
    walk_state_t      state;
    walk_state_t      state_next;

    assign raw        = {bus.Sensor, bus.walkButton};
    assign press_edge = db[WALK] & ~db_walk_d;
    assign ack_rise   = bus.walk_ack & ~ack_d;

    // Two-flop synchronizer bringing both raw inputs into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed from the current one for
    // DEBOUNCE_CYCLES consecutive edges; any bounce back restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERM) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + ONE;
                end
            end
        end
    end

    // Delayed copies used to find the button's rising edge and the ack's
    // leading edge, so a long ack is treated as one acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_walk_d   <= 1'b0;
            press_pulse <= 1'b0;
            ack_d       <= 1'b0;
        end else begin
            db_walk_d   <= db[WALK];
            press_pulse <= press_edge;
            ack_d       <= bus.walk_ack;
        end
    end

    // Walk request state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= W_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A fresh press always wins over an acknowledge; a button still held at
    // acknowledge time must be released before it can request again.
    always_comb begin
        state_next = state;
        case (state)
            W_IDLE: begin
                if (press_edge) begin
                    state_next = W_PENDING;
                end
            end
            W_PENDING: begin
                if (ack_rise && !press_edge) begin
                    state_next = db[WALK] ? W_LOCKOUT : W_IDLE;
                end
            end
            W_LOCKOUT: begin
                if (!db[WALK]) begin
                    state_next = W_IDLE;
                end
            end
            default: begin
                state_next = W_IDLE;
            end
        endcase
    end

    assign bus.sensor_active    = db[SENSE];
    assign bus.walk_press_pulse = press_pulse;
    assign bus.walk_req         = (state == W_PENDING);

endmodule

// File: tb/tb_tlc_input_conditioner.sv
// Self-checking bench for tlc_input_conditioner with a short debounce window:
// a hand-derived vector table, directed corner-case sequences, and random
// stimulus compared every cycle against a behavioural reference model.
module tb_tlc_input_conditioner;

    localparam int DC = 4;

    typedef struct {
        bit w;
        bit s;
        bit a;
        bit exp_sensor;
        bit exp_pulse;
        bit exp_req;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    // Reference model state: raw input delay lines, recent synchronized
    // samples, accepted levels and the pedestrian request bookkeeping.
    bit [1:0]    m_wraw;
    bit [1:0]    m_sraw;
    bit [DC-1:0] m_wh;
    bit [DC-1:0] m_sh;
    bit          m_db_w;
    bit          m_db_w_prev;
    bit          m_db_s;
    bit          m_pulse;
    bit          m_req;
    bit          m_lock;
    bit          m_ack_prev;

    vec_t vecs [12];

    tlc_input_conditioner_if bus ();

    tlc_input_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running board clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic modelReset();
        m_wraw      = '0;
        m_sraw      = '0;
        m_wh        = '0;
        m_sh        = '0;
        m_db_w      = 1'b0;
        m_db_w_prev = 1'b0;
        m_db_s      = 1'b0;
        m_pulse     = 1'b0;
        m_req       = 1'b0;
        m_lock      = 1'b0;
        m_ack_prev  = 1'b0;
    endtask

    // One clock edge of the model, using the inputs held before that edge.
    task automatic modelEdge(input bit w, input bit s, input bit a);
        bit s2w;
        bit s2s;
        bit press;
        bit ack_new;
        bit acc_w;
        bit acc_s;
        s2w    = m_wraw[1];
        s2s    = m_sraw[1];
        m_wraw = {m_wraw[0], w};
        m_sraw = {m_sraw[0], s};
        m_wh   = {m_wh[DC-2:0], s2w};
        m_sh   = {m_sh[DC-2:0], s2s};
        acc_w  = (m_wh == {DC{~m_db_w}});
        acc_s  = (m_sh == {DC{~m_db_s}});
        press  = m_db_w && !m_db_w_prev;
        ack_new = a && !m_ack_prev;
        if (press) begin
            m_req  = 1'b1;
            m_lock = 1'b0;
        end else if (m_req && ack_new) begin
            m_req  = 1'b0;
            m_lock = m_db_w;
        end else if (m_lock && !m_db_w) begin
            m_lock = 1'b0;
        end
        m_pulse     = press;
        m_db_w_prev = m_db_w;
        if (acc_w) m_db_w = ~m_db_w;
        if (acc_s) m_db_s = ~m_db_s;
        m_ack_prev  = a;
    endtask

    task automatic checkOutput(input string name);
        checks++;
        if (bus.sensor_active !== m_db_s || bus.walk_press_pulse !== m_pulse ||
            bus.walk_req !== m_req) begin
            failures++;
            $display("[TB] FAIL %s t=%0t: got sensor=%b pulse=%b req=%b, expected %b %b %b",
                     name, $time, bus.sensor_active, bus.walk_press_pulse, bus.walk_req,
                     m_db_s, m_pulse, m_req);
        end
    endtask

    task automatic checkExpect(input string name, input bit es, input bit ep, input bit er);
        checks++;
        if (bus.sensor_active !== es || bus.walk_press_pulse !== ep || bus.walk_req !== er) begin
            failures++;
            $display("[TB] FAIL %s t=%0t: got sensor=%b pulse=%b req=%b, expected %b %b %b",
                     name, $time, bus.sensor_active, bus.walk_press_pulse, bus.walk_req,
                     es, ep, er);
        end
    endtask

    // Drive inputs, take one edge, advance the model, sample 1 unit later.
    task automatic applyStimulus(input bit w, input bit s, input bit a, input string name);
        bus.walkButton = w;
        bus.Sensor     = s;
        bus.walk_ack   = a;
        @(posedge clk);
        modelEdge(w, s, a);
        #1;
        checkOutput(name);
    endtask

    task automatic applyReset();
        bus.walkButton = 1'b0;
        bus.Sensor     = 1'b0;
        bus.walk_ack   = 1'b0;
        rst            = 1'b1;
        modelReset();
        #1;
        checkExpect("reset_async", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkExpect("reset_hold", 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
    endtask

    initial begin
        bit rw;
        bit rs;
        bit ra;

        // Clean press of both inputs, then an acknowledge while still held.
        for (int r = 0; r < 10; r++) begin
            vecs[r] = '{w: 1'b1, s: 1'b1, a: 1'b0,
                        exp_sensor: (r >= 5), exp_pulse: (r == 6), exp_req: (r >= 6)};
        end
        vecs[10] = '{w: 1'b1, s: 1'b1, a: 1'b1, exp_sensor: 1'b1, exp_pulse: 1'b0, exp_req: 1'b0};
        vecs[11] = '{w: 1'b0, s: 1'b0, a: 1'b0, exp_sensor: 1'b1, exp_pulse: 1'b0, exp_req: 1'b0};

        rst = 1'b1;
        applyReset();

        for (int r = 0; r < 12; r++) begin
            applyStimulus(vecs[r].w, vecs[r].s, vecs[r].a, "table_model");
            checkExpect("table_vec", vecs[r].exp_sensor, vecs[r].exp_pulse, vecs[r].exp_req);
        end

        // Short bounces on the button and a too-short sensor pulse.
        applyReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i < 8) && ((i % 4) < 2), (i < 3), 1'b0, "bounce_model");
            checkExpect("bounce_reject", 1'b0, 1'b0, 1'b0);
        end

        // Acknowledge while the button is held: locked out until release.
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, "held_model");
        checkExpect("held_req_set", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, "held_ack_model");
        checkExpect("ack_held_button", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, "lockout_model");
        checkExpect("lockout_no_rerequest", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, "release_model");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, "repress_model");
            if (i == 6) checkExpect("repress_pulse", 1'b0, 1'b1, 1'b1);
        end
        checkExpect("repress_after_lockout", 1'b0, 1'b0, 1'b1);

        // Ack landing in the same cycle as a new press edge keeps the request.
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, "sim_press_model");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, "sim_release_model");
        checkExpect("pending_after_release", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, "sim_repress_model");
        applyStimulus(1'b1, 1'b0, 1'b1, "sim_ack_model");
        checkExpect("ack_with_press", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, "sim_ack_held_model");
        checkExpect("held_ack_single", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, "sim_ack_drop_model");

        // Ack with nothing pending does nothing, and does not poison a later press.
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1, "idle_ack_model");
        checkExpect("ack_in_idle", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, "idle_ack_drop_model");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, "idle_press_model");
        checkExpect("press_after_idle_ack", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges with a request pending and the
        // sensor partway through its window.
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, "arst_press_model");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, "arst_sense_model");
        checkExpect("arst_before", 1'b0, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        modelReset();
        #1;
        checkExpect("async_reset", 1'b0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, "rewindow_model");
            if (i == 4) checkExpect("sensor_rewindow", 1'b0, 1'b0, 1'b0);
        end
        checkExpect("sensor_after_window", 1'b1, 1'b0, 1'b0);

        // Random traffic with slow-changing inputs so presses get through.
        applyReset();
        rw = 1'b0;
        rs = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) rw = ~rw;
            if ($urandom_range(7) == 0) rs = ~rs;
            ra = ($urandom_range(9) == 0);
            applyStimulus(rw, rs, ra, "random_model");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
